mac_job_scheduler: RTL and testbench

- Sequences the 32x32 pipelined vector-multiply datapath over a job of N consecutive vectors.
- Per vector: generates operand-buffer read addresses, MAC clear/enable/last strobes aligned to read latency, pipeline drain, then a result write-back handshake.
- Sits between the host command interface and the operand SRAMs plus MAC array. Replaces the free-running single-shot step counter with a job-level controller.

---
 rtl/mac_ctrl_pkg.sv | 21 ++
 rtl/mac_strobe_delay.sv | 38 +++
 rtl/mac_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_mac_job_scheduler.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared types and default sizing for the MAC job scheduler.
// Holds the FSM state enum, default constants and derived widths.
package mac_ctrl_pkg;

  localparam int MAT_SIZE = 32;
  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 2;
  localparam int ADDR_W   = 10;
  localparam int VEC_W    = 6;

  localparam int ELEM_W  = $clog2(MAT_SIZE);
  localparam int DRAIN_W = $clog2(RD_LAT + PIPE_LAT);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    WB
  } state_t;

endpackage

// File: rtl/mac_strobe_delay.sv
// Aligns {rd_en, first, last} with SRAM read data: a DEPTH-deep shift
// register. Ports: clk, rst (sync), in_* strobes, out_* delayed strobes.
module mac_strobe_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_en,
  input  logic in_first,
  input  logic in_last,
  output logic out_en,
  output logic out_clr,
  output logic out_last
);

  logic [2:0] sr_q [DEPTH];
  logic [2:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = {in_en, in_first, in_last};
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign {out_en, out_clr, out_last} = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_job_scheduler.sv
// Job-level controller for the vector-multiply datapath: feed, drain
// and write-back per vector. Ports: cmd_* job in, rd_* / mac_* / res_* out.
module mac_job_scheduler
  import mac_ctrl_pkg::*;
#(
  parameter int MAT_SIZE = mac_ctrl_pkg::MAT_SIZE,
  parameter int RD_LAT   = mac_ctrl_pkg::RD_LAT,
  parameter int PIPE_LAT = mac_ctrl_pkg::PIPE_LAT,
  parameter int ADDR_W   = mac_ctrl_pkg::ADDR_W,
  parameter int VEC_W    = mac_ctrl_pkg::VEC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VEC_W-1:0]  cmd_vec_last,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [ADDR_W-1:0] cmd_base_o,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam int EW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
  localparam int DW = $clog2(RD_LAT + PIPE_LAT);
  localparam logic [EW-1:0] ELEM_LAST  = EW'(MAT_SIZE - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT + PIPE_LAT - 1);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_last_q, vec_last_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [ADDR_W-1:0] base_o_q, base_o_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [EW-1:0]     elem_q, elem_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              done_q, done_d;
  logic              feed, first, last;

  always_comb begin
    feed       = (state_q == FEED);
    cmd_ready  = (state_q == IDLE) && !rst;
    state_d    = state_q;
    vec_last_d = vec_last_q;
    vec_d      = vec_q;
    base_o_d   = base_o_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    elem_d     = elem_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          vec_last_d = cmd_vec_last;
          base_o_d   = cmd_base_o;
          addr_a_d   = cmd_base_a;
          addr_b_d   = cmd_base_b;
          vec_d      = '0;
          elem_d     = '0;
          state_d    = FEED;
        end
      end
      FEED: begin
        addr_a_d = addr_a_q + 1'b1;
        addr_b_d = addr_b_q + 1'b1;
        elem_d   = elem_q + 1'b1;
        if (elem_q == ELEM_LAST) begin
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = WB;
        end
      end
      WB: begin
        if (res_ready) begin
          if (vec_q == vec_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // address registers keep running into the next vector
            vec_d   = vec_q + 1'b1;
            elem_d  = '0;
            state_d = FEED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_last_q <= '0;
      vec_q      <= '0;
      base_o_q   <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      elem_q     <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_last_q <= vec_last_d;
      vec_q      <= vec_d;
      base_o_q   <= base_o_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      elem_q     <= elem_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
    end
  end

  assign first     = feed && (elem_q == '0);
  assign last      = feed && (elem_q == ELEM_LAST);
  assign rd_en     = feed;
  assign rd_addr_a = feed ? addr_a_q : '0;
  assign rd_addr_b = feed ? addr_b_q : '0;
  assign res_valid = (state_q == WB);
  assign res_addr  = res_valid ? base_o_q + ADDR_W'(vec_q) : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  mac_strobe_delay #(
    .DEPTH(RD_LAT)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_en    (rd_en),
    .in_first (first),
    .in_last  (last),
    .out_en   (mac_en),
    .out_clr  (mac_clr),
    .out_last (mac_last)
  );

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: default build plus an
// RD_LAT=3 / PIPE_LAT=4 build sharing the clock and reset.
module tb_mac_job_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [5:0] cmd_vec_last;
  logic [9:0] cmd_base_a, cmd_base_b, cmd_base_o;
  logic       rd_en;
  logic [9:0] rd_addr_a, rd_addr_b;
  logic       mac_en, mac_clr, mac_last;
  logic       res_valid, res_ready;
  logic [9:0] res_addr;
  logic       busy, done;

  logic       l_cmd_valid, l_cmd_ready;
  logic       l_rd_en;
  logic [9:0] l_rd_addr_a, l_rd_addr_b;
  logic       l_mac_en, l_mac_clr, l_mac_last;
  logic       l_res_valid, l_res_ready;
  logic [9:0] l_res_addr;
  logic       l_busy, l_done;

  int tests = 0;
  int fails = 0;

  mac_job_scheduler u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vec_last(cmd_vec_last),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
    .cmd_base_o(cmd_base_o),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .busy(busy), .done(done)
  );

  mac_job_scheduler #(.RD_LAT(3), .PIPE_LAT(4)) u_lat (
    .clk(clk), .rst(rst),
    .cmd_valid(l_cmd_valid), .cmd_ready(l_cmd_ready),
    .cmd_vec_last(cmd_vec_last),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
    .cmd_base_o(cmd_base_o),
    .rd_en(l_rd_en), .rd_addr_a(l_rd_addr_a), .rd_addr_b(l_rd_addr_b),
    .mac_en(l_mac_en), .mac_clr(l_mac_clr), .mac_last(l_mac_last),
    .res_valid(l_res_valid), .res_ready(l_res_ready),
    .res_addr(l_res_addr), .busy(l_busy), .done(l_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] vl, input logic [9:0] a,
                       input logic [9:0] b, input logic [9:0] o);
    cmd_valid    = 1'b1;
    cmd_vec_last = vl;
    cmd_base_a   = a;
    cmd_base_b   = b;
    cmd_base_o   = o;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    l_cmd_valid = 1'b0;
    res_ready = 1'b1;
    l_res_ready = 1'b1;
    cmd_vec_last = '0;
    cmd_base_a = '0;
    cmd_base_b = '0;
    cmd_base_o = '0;
    step();
    step();
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
    end
    tests++;
    if ({busy, rd_en, mac_en, mac_clr, mac_last, res_valid, done}
        !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0",
               {busy, rd_en, mac_en, mac_clr, mac_last, res_valid, done});
    end
    tests++;
    if ({rd_addr_a, rd_addr_b, res_addr} !== 30'b0) begin
      fails++;
      $display("FAIL reset_addrs: got %h want 0",
               {rd_addr_a, rd_addr_b, res_addr});
    end
    tests++;
    if ({l_busy, l_rd_en, l_mac_en, l_mac_clr, l_mac_last, l_res_valid,
         l_done, l_rd_addr_a, l_rd_addr_b, l_res_addr} !== 37'b0) begin
      fails++;
      $display("FAIL reset_lat_outputs: got nonzero want 0");
    end
    rst = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || l_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_high: got %b%b want 11",
               cmd_ready, l_cmd_ready);
    end
  endtask

  task automatic test_single();
    logic e_en, e_clr;
    res_ready = 1'b1;
    issue(6'd0, 10'h100, 10'h200, 10'h300);
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (rd_en !== 1'b1 || rd_addr_a !== 10'h100 + k ||
          rd_addr_b !== 10'h200 + k) begin
        fails++;
        $display("FAIL single_rd k=%0d: got %b %h %h want 1 %h %h", k,
                 rd_en, rd_addr_a, rd_addr_b, 10'h100 + k, 10'h200 + k);
      end
      e_en  = (k >= 1);
      e_clr = (k == 1);
      tests++;
      if ({mac_en, mac_clr, mac_last} !== {e_en, e_clr, 1'b0}) begin
        fails++;
        $display("FAIL single_mac k=%0d: got %b want %b", k,
                 {mac_en, mac_clr, mac_last}, {e_en, e_clr, 1'b0});
      end
      step();
    end
    tests++;
    if ({rd_en, mac_en, mac_clr, mac_last} !== 4'b0101) begin
      fails++;
      $display("FAIL single_last_mac: got %b want 0101",
               {rd_en, mac_en, mac_clr, mac_last});
    end
    step();
    step();
    tests++;
    if (mac_en !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: got %b%b want 00", mac_en, res_valid);
    end
    step();
    tests++;
    if (res_valid !== 1'b1 || res_addr !== 10'h300) begin
      fails++;
      $display("FAIL single_wb: got %b %h want 1 300", res_valid, res_addr);
    end
    step();
    tests++;
    if ({done, busy, cmd_ready, res_valid} !== 4'b1010) begin
      fails++;
      $display("FAIL single_done: got %b want 1010",
               {done, busy, cmd_ready, res_valid});
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] ra [128];
    int n = 0;
    int hs = 0;
    int dn = 0;
    res_ready = 1'b1;
    issue(6'd3, 10'h3F0, 10'h000, 10'h010);
    for (int i = 0; i < 170; i++) begin
      if (rd_en) begin
        if (n < 128) ra[n] = rd_addr_a;
        n++;
      end
      if (res_valid && res_ready) begin
        tests++;
        if (res_addr !== 10'h010 + hs) begin
          fails++;
          $display("FAIL wrap_res_addr %0d: got %h want %h", hs,
                   res_addr, 10'h010 + hs);
        end
        hs++;
      end
      if (done) dn++;
      step();
    end
    tests++;
    if (n !== 128) begin
      fails++;
      $display("FAIL wrap_rd_count: got %0d want 128", n);
    end else begin
      tests++;
      if (ra[0] !== 10'h3F0 || ra[16] !== 10'h000) begin
        fails++;
        $display("FAIL wrap_v0: got %h %h want 3f0 000", ra[0], ra[16]);
      end
      tests++;
      if (ra[64] !== 10'h030 || ra[95] !== 10'h04F) begin
        fails++;
        $display("FAIL wrap_v2: got %h %h want 030 04f", ra[64], ra[95]);
      end
    end
    tests++;
    if (hs !== 4 || dn !== 1) begin
      fails++;
      $display("FAIL wrap_counts: got hs=%0d done=%0d want 4 1", hs, dn);
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    res_ready = 1'b0;
    issue(6'd1, 10'h000, 10'h100, 10'h050);
    while (!res_valid && w < 100) begin
      step();
      w++;
    end
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_timeout: got %b want 1", res_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (res_valid !== 1'b1 || res_addr !== 10'h050 || rd_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold %0d: got %b %h %b want 1 050 0", i,
                 res_valid, res_addr, rd_en);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    tests++;
    if (rd_en !== 1'b1 || rd_addr_a !== 10'h020 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_feed: got %b %h %b want 1 020 0",
               rd_en, rd_addr_a, res_valid);
    end
    w = 0;
    while (!done && w < 100) begin
      if (res_valid) begin
        tests++;
        if (res_addr !== 10'h051) begin
          fails++;
          $display("FAIL bp_res_addr2: got %h want 051", res_addr);
        end
      end
      step();
      w++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: got %b want 1", done);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int w = 0;
    res_ready = 1'b1;
    issue(6'd0, 10'h040, 10'h0C0, 10'h070);
    repeat (17) step();
    tests++;
    if (rd_addr_a !== 10'h051) begin
      fails++;
      $display("FAIL rmid_elem17: got %h want 051", rd_addr_a);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, rd_en, mac_en, mac_clr, mac_last, res_valid, done,
         cmd_ready} !== 8'b00000001) begin
      fails++;
      $display("FAIL rmid_outputs: got %b want 00000001",
               {busy, rd_en, mac_en, mac_clr, mac_last, res_valid, done,
                cmd_ready});
    end
    for (int i = 0; i < 60; i++) begin
      step();
      if (res_valid || done || busy) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rmid_quiet: got %0d events want 0", bad);
    end
    issue(6'd0, 10'h080, 10'h0A0, 10'h071);
    tests++;
    if (rd_addr_a !== 10'h080 || mac_en !== 1'b0) begin
      fails++;
      $display("FAIL rmid_restart: got %h %b want 080 0", rd_addr_a, mac_en);
    end
    step();
    tests++;
    if (mac_en !== 1'b1 || mac_clr !== 1'b1) begin
      fails++;
      $display("FAIL rmid_clr: got %b%b want 11", mac_en, mac_clr);
    end
    while (!done && w < 100) begin
      if (res_valid) begin
        tests++;
        if (res_addr !== 10'h071) begin
          fails++;
          $display("FAIL rmid_res_addr: got %h want 071", res_addr);
        end
      end
      step();
      w++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL rmid_done: got %b want 1", done);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int w = 0;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_vec_last = 6'd0;
    cmd_base_a = 10'h000;
    cmd_base_b = 10'h000;
    cmd_base_o = 10'h100;
    step();
    while (!done && w < 100) begin
      if (busy && cmd_ready) bad++;
      step();
      w++;
    end
    tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done_ready: got %b%b want 11", done, cmd_ready);
    end
    cmd_base_a = 10'h200;
    cmd_base_o = 10'h101;
    step();
    cmd_valid = 1'b0;
    tests++;
    if (rd_en !== 1'b1 || rd_addr_a !== 10'h200) begin
      fails++;
      $display("FAIL b2b_second_feed: got %b %h want 1 200",
               rd_en, rd_addr_a);
    end
    w = 0;
    while (!done && w < 100) begin
      if (busy && cmd_ready) bad++;
      if (res_valid) begin
        tests++;
        if (res_addr !== 10'h101) begin
          fails++;
          $display("FAIL b2b_res_addr: got %h want 101", res_addr);
        end
      end
      step();
      w++;
    end
    tests++;
    if (done !== 1'b1 || bad !== 0) begin
      fails++;
      $display("FAIL b2b_ready_busy: got done=%b bad=%0d want 1 0",
               done, bad);
    end
  endtask

  task automatic test_latency();
    logic [2:0] hist = 3'b0;
    int first_rd = -1;
    int first_mac = -1;
    int last_mac = -1;
    int wb = -1;
    int bad = 0;
    int dn = 0;
    cmd_vec_last = 6'd0;
    cmd_base_a = 10'h010;
    cmd_base_b = 10'h020;
    cmd_base_o = 10'h030;
    l_cmd_valid = 1'b1;
    step();
    l_cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (l_mac_en !== hist[2]) bad++;
      if (l_rd_en && first_rd < 0) first_rd = i;
      if (l_mac_en && first_mac < 0) first_mac = i;
      if (l_mac_en) last_mac = i;
      if (l_res_valid && wb < 0) wb = i;
      if (l_done) dn++;
      hist = {hist[1:0], l_rd_en};
      step();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL lat_shift: got %0d mismatches want 0", bad);
    end
    tests++;
    if (first_rd < 0 || first_mac - first_rd !== 3) begin
      fails++;
      $display("FAIL lat_rd_to_mac: got %0d want 3", first_mac - first_rd);
    end
    // PIPE_LAT idle cycles between the last mac_en and the WB cycle
    tests++;
    if (wb < 0 || wb - last_mac !== 5) begin
      fails++;
      $display("FAIL lat_mac_to_wb: got %0d want 5", wb - last_mac);
    end
    tests++;
    if (dn !== 1) begin
      fails++;
      $display("FAIL lat_done: got %0d want 1", dn);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
